// File: rtl/sa_cnt_sequencer.sv
// Step-count sequencer for the systolic-array enable decoder: one 0..LAST_CNT pass per start,
// with stall, abort and a one-cycle done pulse. Optional pass counter behind SA_SEQ_PASS_CNT_EN.
module sa_cnt_sequencer #(
    parameter int CNT_W    = 4,
    parameter int LAST_CNT = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             abort_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             cnt_valid_o,
    output logic             busy_o,
`ifdef SA_SEQ_PASS_CNT_EN
    output logic [7:0]       pass_cnt_o,
`endif
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST = LAST_CNT[CNT_W-1:0];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_i) state_d = RUN;
            end
            RUN: begin
                // abort outranks stall; a stalled cycle simply holds everything
                if (abort_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!stall_i) begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign cnt_o       = cnt_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cnt_valid_o = (state_q == RUN) && !stall_i;

`ifdef SA_SEQ_PASS_CNT_EN
    logic [7:0] pass_cnt_q;

    // bumps on the edge that raises done, so the new count shows alongside the pulse
    always_ff @(posedge clk_i) begin
        if (rst_i)       pass_cnt_q <= 8'd0;
        else if (done_d) pass_cnt_q <= pass_cnt_q + 8'd1;
    end

    assign pass_cnt_o = pass_cnt_q;
`endif

endmodule

// File: tb/tb_sa_cnt_sequencer.sv
// Scoreboard bench for sa_cnt_sequencer: a position-based reference model pushes one expected
// output record per cycle; a negedge monitor pops and compares against the DUT.
module tb_sa_cnt_sequencer;
    localparam int CNT_W    = 4;
    localparam int LAST_CNT = 8;

    logic             clk = 1'b0;
    logic             rst, start, stall, abort;
    logic [CNT_W-1:0] cnt;
    logic             cnt_valid, busy, done;
`ifdef SA_SEQ_PASS_CNT_EN
    logic [7:0]       pass_cnt;
`endif

    always #5 clk = ~clk;

    sa_cnt_sequencer #(.CNT_W(CNT_W), .LAST_CNT(LAST_CNT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stall_i     (stall),
        .abort_i     (abort),
        .cnt_o       (cnt),
        .cnt_valid_o (cnt_valid),
        .busy_o      (busy),
`ifdef SA_SEQ_PASS_CNT_EN
        .pass_cnt_o  (pass_cnt),
`endif
        .done_o      (done)
    );

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             vld;
        logic             busy;
        logic             done;
        logic [7:0]       pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model: pos = -1 idle, 0..LAST_CNT the step in progress, LAST_CNT+1 the done cycle.
    int   pos  = -1;
    int   pcnt = 0;

    task automatic step(input logic st, input logic sl, input logic ab, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        start = st; stall = sl; abort = ab; rst = r;
        e.cnt  = (pos >= 0 && pos <= LAST_CNT) ? CNT_W'(pos) : '0;
        e.vld  = (pos >= 0 && pos <= LAST_CNT) && !sl;
        e.busy = (pos >= 0);
        e.done = (pos == LAST_CNT + 1);
        e.pc   = 8'(pcnt);
        sb_q.push_back(e);
        if (r) begin
            pos  = -1;
            pcnt = 0;
        end else if (pos < 0) begin
            if (st) pos = 0;
        end else if (pos == LAST_CNT + 1) begin
            pos = -1;
        end else if (ab) begin
            pos = -1;
        end else if (!sl) begin
            pos++;
            if (pos == LAST_CNT + 1) pcnt = (pcnt + 1) % 256;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (cnt !== e.cnt || cnt_valid !== e.vld || busy !== e.busy || done !== e.done) begin
                n_err++;
                $display("FAIL outputs t=%0t: got cnt=%0d vld=%b busy=%b done=%b, want cnt=%0d vld=%b busy=%b done=%b",
                         $time, cnt, cnt_valid, busy, done, e.cnt, e.vld, e.busy, e.done);
            end
`ifdef SA_SEQ_PASS_CNT_EN
            n_vec++;
            if (pass_cnt !== e.pc) begin
                n_err++;
                $display("FAIL pass_cnt t=%0t: got %0d, want %0d", $time, pass_cnt, e.pc);
            end
`endif
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;
        @(posedge clk);
        step(1'b0, 1'b0, 1'b0, 1'b1);   // reset state
        idle(2);

        // plain pass
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(13);

        // two stall cycles while cnt=4
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(10);

        // abort together with stall while cnt=5, then restart
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(12);

        // start held high: back-to-back passes, start ignored in RUN/DONE
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(12);

        // reset while cnt=6, then a normal pass
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(12);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 3,  $urandom_range(0, 199) < 1);
        idle(12);

`ifdef SA_SEQ_PASS_CNT_EN
        // three full passes plus an aborted one, then a 256-pass wrap
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3 * (LAST_CNT + 3); i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 256 * (LAST_CNT + 3); i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
`endif

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d records left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
